// File: rtl/apb_slave_mem_pkg.sv
// Shared types and sizing helpers for the apb_slave_mem register block.
// The optional byte-strobe port is enabled with APB_SLAVE_MEM_PSTRB_EN.
package apb_slave_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  // Wide enough for the full 0..15 wait-state range.
  localparam int unsigned WAIT_CNT_W = 4;

  function automatic int unsigned byte_lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic int unsigned addr_shift(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned APB_DEF_DATA_W = 32;
  localparam int unsigned APB_DEF_LANES  = byte_lanes(APB_DEF_DATA_W);
  localparam int unsigned APB_DEF_SHIFT  = addr_shift(APB_DEF_DATA_W);

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word storage: async clear, registered read port, byte-enabled write port.
module apb_mem_array
  import apb_slave_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int unsigned LANES = byte_lanes(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (wr_be[b]) begin
          mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // rd_zero returns zero for an errored access instead of touching an out-of-range word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? '0 : mem[rd_idx];
    end
  end

endmodule

// File: rtl/apb_slave_mem.sv
// Parametrised APB slave terminating transfers into an internal word array.
// Define APB_SLAVE_MEM_PSTRB_EN to add the pstrb port and byte-masked writes.
module apb_slave_mem
  import apb_slave_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_SLAVE_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int unsigned LANES  = byte_lanes(DATA_W);
  localparam int unsigned SHIFT  = addr_shift(DATA_W);
  localparam int unsigned IDX_W  = idx_width(DEPTH);
  localparam int unsigned FULL_W = ADDR_W - SHIFT;

  apb_slv_state_e        state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  lat_write;
  logic                  lat_err;
  logic [IDX_W-1:0]      lat_idx;

  logic [FULL_W-1:0]     full_idx;
  logic [IDX_W-1:0]      idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  addr_err;
  logic                  setup;
  logic                  done;
  logic                  wr_en;
  logic [LANES-1:0]      wr_be;

  assign full_idx = paddr[ADDR_W-1:SHIFT];
  assign idx      = IDX_W'(full_idx);

  generate
    if (SHIFT > 0) begin : g_align
      assign misaligned = |paddr[SHIFT-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  // Range test on the full index so upper address bits are never silently dropped.
  assign out_of_range = 32'(full_idx) >= DEPTH;
  assign addr_err     = misaligned | out_of_range;

  assign setup   = (state == IDLE) && psel && !penable;
  assign pready  = (state == ACCESS) && (cnt == '0);
  assign pslverr = pready ? lat_err : APB_RESP_OKAY;
  assign done    = pready && psel && penable;
  assign wr_en   = done && lat_write && (lat_err == APB_RESP_OKAY);

`ifdef APB_SLAVE_MEM_PSTRB_EN
  assign wr_be = pstrb;
`else
  assign wr_be = '1;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_err   <= APB_RESP_OKAY;
      lat_idx   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (setup) begin
            state     <= ACCESS;
            cnt       <= WAIT_CNT_W'(WAIT_CYCLES);
            lat_write <= pwrite;
            lat_idx   <= idx;
            lat_err   <= addr_err ? APB_RESP_ERR : APB_RESP_OKAY;
          end
        end
        ACCESS: begin
          // Dropping psel mid-access abandons the transfer; no write is issued.
          if (!psel) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - WAIT_CNT_W'(1);
          end else if (penable) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  apb_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (pclk),
    .rst_n   (presetn),
    .rd_en   (setup && !pwrite),
    .rd_zero (addr_err),
    .rd_idx  (idx),
    .rd_data (prdata),
    .wr_en   (wr_en),
    .wr_idx  (lat_idx),
    .wr_be   (wr_be),
    .wr_data (pwdata)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances with 0, 3 and 4 wait states.
// Byte-strobe vectors run only when APB_SLAVE_MEM_PSTRB_EN is defined.
module tb_apb_slave_mem;

  localparam int unsigned W0 = 0;
  localparam int unsigned W1 = 3;
  localparam int unsigned W2 = 4;

  logic        pclk;
  logic        presetn [3];
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [7:0]  paddr   [3];
  logic [31:0] pwdata  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
`ifdef APB_SLAVE_MEM_PSTRB_EN
  logic [3:0]  pstrb   [3];
`endif

  int unsigned checks;
  int unsigned errors;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(W0)) u_w0 (
    .pclk(pclk), .presetn(presetn[0]), .psel(psel[0]), .penable(penable[0]),
    .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_SLAVE_MEM_PSTRB_EN
    .pstrb(pstrb[0]),
`endif
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(W1)) u_w3 (
    .pclk(pclk), .presetn(presetn[1]), .psel(psel[1]), .penable(penable[1]),
    .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_SLAVE_MEM_PSTRB_EN
    .pstrb(pstrb[1]),
`endif
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(W2)) u_w4 (
    .pclk(pclk), .presetn(presetn[2]), .psel(psel[2]), .penable(penable[2]),
    .pwrite(pwrite[2]), .paddr(paddr[2]), .pwdata(pwdata[2]),
`ifdef APB_SLAVE_MEM_PSTRB_EN
    .pstrb(pstrb[2]),
`endif
    .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2])
  );

  function automatic int unsigned wait_of(input int unsigned u);
    return (u == 0) ? W0 : (u == 1) ? W1 : W2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Entered and left #1 after a rising edge, so consecutive calls run back-to-back.
  task automatic xfer(input int unsigned u, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err, output int unsigned waits);
    psel[u]    = 1'b1;
    penable[u] = 1'b0;
    pwrite[u]  = wr;
    paddr[u]   = addr;
    pwdata[u]  = wdata;
`ifdef APB_SLAVE_MEM_PSTRB_EN
    pstrb[u]   = strb;
`endif
    @(posedge pclk); #1;
    penable[u] = 1'b1;
    waits = 0;
    while (!pready[u] && waits < 40) begin
      @(posedge pclk); #1;
      waits++;
    end
    rdata = prdata[u];
    err   = pslverr[u];
    @(posedge pclk); #1;
    psel[u]    = 1'b0;
    penable[u] = 1'b0;
  endtask

  task automatic apb_wr(input int unsigned u, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic exp_err, input string tag);
    logic [31:0] rdata;
    logic        err;
    int unsigned waits;
    xfer(u, 1'b1, addr, data, strb, rdata, err, waits);
    check({tag, "_wait"}, waits, wait_of(u));
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic apb_rd(input int unsigned u, input logic [7:0] addr, input logic [31:0] exp_data,
                        input logic exp_err, input string tag);
    logic [31:0] rdata;
    logic        err;
    int unsigned waits;
    xfer(u, 1'b0, addr, 32'h0, 4'h0, rdata, err, waits);
    check({tag, "_wait"}, waits, wait_of(u));
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_data"}, rdata, exp_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int u = 0; u < 3; u++) begin
      presetn[u] = 1'b0;
      psel[u]    = 1'b0;
      penable[u] = 1'b0;
      pwrite[u]  = 1'b0;
      paddr[u]   = 8'h0;
      pwdata[u]  = 32'h0;
`ifdef APB_SLAVE_MEM_PSTRB_EN
      pstrb[u]   = 4'h0;
`endif
    end
    repeat (2) @(posedge pclk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check("rst_prdata", prdata[u], 32'h0);
      check("rst_pready", {31'd0, pready[u]}, 32'd0);
      check("rst_pslverr", {31'd0, pslverr[u]}, 32'd0);
    end
    for (int u = 0; u < 3; u++) presetn[u] = 1'b1;
    @(posedge pclk); #1;

    // Zero wait states: write then read back.
    apb_wr(0, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0, "w0_wr04");
    apb_rd(0, 8'h04, 32'hDEADBEEF, 1'b0, "w0_rd04");

    // prdata holds after the read and is untouched by writes.
    repeat (3) @(posedge pclk);
    #1;
    check("hold_idle", prdata[0], 32'hDEADBEEF);

    // Out-of-range and misaligned accesses.
    apb_wr(0, 8'h40, 32'h12345678, 4'hF, 1'b1, "w0_wr40");
    check("hold_errwr", prdata[0], 32'hDEADBEEF);
    apb_rd(0, 8'h40, 32'h0, 1'b1, "w0_rd40");
    apb_wr(0, 8'h06, 32'hFFFFFFFF, 4'hF, 1'b1, "w0_wr06");
    apb_rd(0, 8'h04, 32'hDEADBEEF, 1'b0, "w0_rd04b");
    apb_rd(0, 8'h05, 32'h0, 1'b1, "w0_rd05");
    apb_rd(0, 8'hFC, 32'h0, 1'b1, "w0_rdFC");
    for (int i = 0; i < 16; i++) begin
      apb_rd(0, 8'(i * 4), (i == 1) ? 32'hDEADBEEF : 32'h0, 1'b0, "w0_scan");
    end

    // penable high while idle must not start a transfer.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 8'h00; pwdata[0] = 32'h55555555;
    repeat (2) begin
      @(posedge pclk); #1;
      check("idle_penable_pready", {31'd0, pready[0]}, 32'd0);
    end
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(posedge pclk); #1;
    apb_rd(0, 8'h00, 32'h0, 1'b0, "w0_rd00");

    // Three wait states.
    apb_rd(1, 8'h00, 32'h0, 1'b0, "w3_rd00");
    apb_wr(1, 8'h14, 32'hCAFEF00D, 4'hF, 1'b0, "w3_wr14");
    apb_rd(1, 8'h14, 32'hCAFEF00D, 1'b0, "w3_rd14");

    // Abort by dropping psel mid-access: no write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 8'h18; pwdata[1] = 32'h77777777;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(posedge pclk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); #1;
    check("abort_pready", {31'd0, pready[1]}, 32'd0);
    apb_rd(1, 8'h18, 32'h0, 1'b0, "w3_rd18");

    // Reset in the second access cycle of a write.
    apb_wr(2, 8'h08, 32'h5A5A5A5A, 4'hF, 1'b0, "w4_wr08");
    apb_rd(2, 8'h08, 32'h5A5A5A5A, 1'b0, "w4_rd08");
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 8'h08; pwdata[2] = 32'hA5A5A5A5;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    @(posedge pclk); #1;
    presetn[2] = 1'b0;
    #1;
    check("midrst_prdata", prdata[2], 32'h0);
    check("midrst_pready", {31'd0, pready[2]}, 32'd0);
    check("midrst_pslverr", {31'd0, pslverr[2]}, 32'd0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge pclk); #1;
    presetn[2] = 1'b1;
    @(posedge pclk); #1;
    apb_rd(2, 8'h08, 32'h0, 1'b0, "w4_rd08_post");
    apb_rd(0, 8'h04, 32'hDEADBEEF, 1'b0, "w0_rd04_iso");

`ifdef APB_SLAVE_MEM_PSTRB_EN
    apb_wr(0, 8'h0C, 32'h11223344, 4'hF, 1'b0, "strb_full");
    apb_wr(0, 8'h0C, 32'hAABBCCDD, 4'b0101, 1'b0, "strb_0101");
    apb_rd(0, 8'h0C, 32'h11BB33DD, 1'b0, "strb_rd1");
    apb_wr(0, 8'h0C, 32'hFFFFFFFF, 4'b0000, 1'b0, "strb_none");
    apb_rd(0, 8'h0C, 32'h11BB33DD, 1'b0, "strb_rd2");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
